sprite_blitter: RTL and testbench

Copies one 96x64 RGB565 sprite image from a combinational sprite ROM into the OLED frame buffer at a signed screen offset, with optional horizontal mirroring, transparency keying and clipping. It drives the ROM's `pixel_index` input and consumes its `oled_colour` output, which is the reverse of normal display scan. It sits between the game-state logic (fighter position, facing, hit state) and the frame-buffer write port. It runs once per `start` pulse and signals completion with `done`.

---
 rtl/sprite_blitter.sv | 150 +++++++++++++++
 tb/tb_sprite_blitter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a 96x64 RGB565 sprite from a combinational ROM into the
// frame buffer at a signed offset, with horizontal mirroring, key-colour
// transparency and clipping. One source pixel per cycle; writes trail the ROM
// address by one cycle.
// Optional feature macro: BLIT_TINT_EN (hit-flash tint of every written pixel).
module sprite_blitter #(
    parameter int unsigned SPR_W  = 96,
    parameter int unsigned SPR_H  = 64,
    parameter int unsigned SCR_W  = 96,
    parameter int unsigned SCR_H  = 64,
    parameter logic [15:0] TRANSP = 16'h0000,
    parameter logic [15:0] TINT   = 16'hF800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  pos_x,
    input  logic [7:0]  pos_y,
    input  logic        flip_h,
    input  logic        tint,
    output logic [12:0] pixel_index,
    input  logic [15:0] oled_colour,
    output logic        fb_we,
    output logic [12:0] fb_addr,
    output logic [15:0] fb_data,
    output logic        busy,
    output logic        done
);

    localparam int unsigned NPIX = SPR_W * SPR_H;
    localparam int unsigned XW   = $clog2(SPR_W);
    localparam int unsigned YW   = $clog2(SPR_H);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   sx_q;      // column of the index currently on pixel_index
    logic [YW-1:0]   sy_q;      // row of the index currently on pixel_index
    logic [7:0]      pos_x_q;
    logic [7:0]      pos_y_q;
    logic            flip_q;
    logic            last_pix;
    logic [XW-1:0]   ex;
    logic [9:0]      dx;
    logic [9:0]      dy;
    logic            on_screen;
    logic [12:0]     wr_addr;
    logic [15:0]     wr_data;

`ifdef BLIT_TINT_EN
    logic            tint_q;

    // Latch the tint request alongside the other per-blit parameters.
    always_ff @(posedge clk) begin
        if (reset) begin
            tint_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            tint_q <= tint;
        end
    end

    assign wr_data = tint_q ? TINT : oled_colour;
`else
    logic            unused_tint;
    assign unused_tint = tint;
    assign wr_data     = oled_colour;
`endif

    assign last_pix = (pixel_index == 13'(NPIX - 1));

    // Destination coordinates of the presented source pixel, 10-bit signed.
    always_comb begin
        ex        = flip_q ? (XW'(SPR_W - 1) - sx_q) : sx_q;
        dx        = {{2{pos_x_q[7]}}, pos_x_q} + {{(10 - XW){1'b0}}, ex};
        dy        = {{2{pos_y_q[7]}}, pos_y_q} + {{(10 - YW){1'b0}}, sy_q};
        // Sign bit clear means non-negative; then an unsigned compare is safe.
        on_screen = !dx[9] && (dx < 10'(SCR_W)) && !dy[9] && (dy < 10'(SCR_H));
        wr_addr   = 13'(dy) * 13'(SCR_W) + 13'(dx);
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            StIdle:  if (start) state_d = StScan;
            StScan: begin
                busy = 1'b1;
                if (last_pix) state_d = StDrain;
            end
            StDrain: begin
                busy    = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register, source counters and the registered write stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pixel_index <= 13'd0;
            sx_q        <= '0;
            sy_q        <= '0;
            pos_x_q     <= 8'd0;
            pos_y_q     <= 8'd0;
            flip_q      <= 1'b0;
            fb_we       <= 1'b0;
            fb_addr     <= 13'd0;
            fb_data     <= 16'd0;
        end else begin
            state_q <= state_d;
            fb_we   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        pos_x_q     <= pos_x;
                        pos_y_q     <= pos_y;
                        flip_q      <= flip_h;
                        pixel_index <= 13'd0;
                        sx_q        <= '0;
                        sy_q        <= '0;
                    end
                end
                StScan: begin
                    fb_we   <= (oled_colour != TRANSP) && on_screen;
                    fb_addr <= wr_addr;
                    fb_data <= wr_data;
                    if (!last_pix) begin
                        pixel_index <= pixel_index + 13'd1;
                        if (sx_q == XW'(SPR_W - 1)) begin
                            sx_q <= '0;
                            sy_q <= sy_q + YW'(1);
                        end else begin
                            sx_q <= sx_q + XW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter with a behavioural ROM stub.
module tb_sprite_blitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  pos_x;
    logic [7:0]  pos_y;
    logic        flip_h;
    logic        tint;
    logic [12:0] pixel_index;
    logic [15:0] oled_colour;
    logic        fb_we;
    logic [12:0] fb_addr;
    logic [15:0] fb_data;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    // ROM stub: mode 0 returns index|1, mode 1 is transparent except index 2249.
    int mode = 0;
    always_comb begin
        if (mode == 0) oled_colour = {3'b000, pixel_index} | 16'd1;
        else           oled_colour = (pixel_index == 13'd2249) ? 16'hFFDF : 16'h0000;
    end

    sprite_blitter dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .flip_h      (flip_h),
        .tint        (tint),
        .pixel_index (pixel_index),
        .oled_colour (oled_colour),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Run statistics gathered on the falling edge; c0 is the start cycle.
    int          c0 = 0;
    int          rel;
    int          wr_cnt, map_err, done_cnt, done_rel, first_rel, last_rel;
    logic [12:0] prev_pix, first_addr, first_src, addr_of0, addr_of95;
    logic [12:0] pix_at1, pix_at_last;
    logic [15:0] first_data;
    logic        busy_at1, busy_at6145, busy_at6146;

    always @(negedge clk) begin
        rel = cyc - c0;
        if (fb_we) begin
            wr_cnt++;
            if (wr_cnt == 1) begin
                first_addr = fb_addr;
                first_data = fb_data;
                first_src  = prev_pix;
                first_rel  = rel;
            end
            last_rel = rel;
            if (fb_addr !== prev_pix || fb_data !== ({3'b000, fb_addr} | 16'd1)) map_err++;
            if (prev_pix == 13'd0)  addr_of0  = fb_addr;
            if (prev_pix == 13'd95) addr_of95 = fb_addr;
        end
        if (done) begin
            done_cnt++;
            done_rel = rel;
        end
        if (rel == 1) begin
            pix_at1  = pixel_index;
            busy_at1 = busy;
        end
        if (rel == 6144) pix_at_last = pixel_index;
        if (rel == 6145) busy_at6145 = busy;
        if (rel == 6146) busy_at6146 = busy;
        prev_pix = pixel_index;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        wr_cnt     = 0;
        map_err    = 0;
        done_cnt   = 0;
        done_rel   = -1;
        first_rel  = -1;
        last_rel   = -1;
        first_addr = '1;
        first_src  = '1;
        first_data = '1;
        addr_of0   = '1;
        addr_of95  = '1;
    endtask

    // Pulse start (sampled in cycle 0); returns at the falling edge of cycle 1.
    task automatic start_blit(input logic [7:0] px, input logic [7:0] py,
                              input logic fl, input logic tn);
        @(negedge clk);
        pos_x  = px;
        pos_y  = py;
        flip_h = fl;
        tint   = tn;
        start  = 1'b1;
        clear_stats();
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 7000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        pos_x  = 8'd0;
        pos_y  = 8'd0;
        flip_h = 1'b0;
        tint   = 1'b0;
        clear_stats();

        // Power-up reset
        repeat (2) @(negedge clk);
        chk("rst_pixel_index", 32'(pixel_index), 32'd0);
        chk("rst_fb_we",       32'(fb_we),       32'd0);
        chk("rst_fb_addr",     32'(fb_addr),     32'd0);
        chk("rst_fb_data",     32'(fb_data),     32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_done",        32'(done),        32'd0);
        reset = 1'b0;
        clear_stats();
        repeat (100) @(negedge clk);
        chk("idle_no_writes", 32'(wr_cnt), 32'd0);

        // Opaque copy at (0,0)
        mode = 0;
        start_blit(8'd0, 8'd0, 1'b0, 1'b0);
        wait_done("opaque");
        chk("opaque_writes",     32'(wr_cnt),      32'd6144);
        chk("opaque_map_err",    32'(map_err),     32'd0);
        chk("opaque_done_cycle", 32'(done_rel),    32'd6146);
        chk("opaque_done_count", 32'(done_cnt),    32'd1);
        chk("opaque_first_wr",   32'(first_rel),   32'd2);
        chk("opaque_last_wr",    32'(last_rel),    32'd6145);
        chk("opaque_pix_c1",     32'(pix_at1),     32'd0);
        chk("opaque_pix_c6144",  32'(pix_at_last), 32'd6143);
        chk("opaque_busy_c1",    32'(busy_at1),    32'd1);
        chk("opaque_busy_c6145", 32'(busy_at6145), 32'd1);
        chk("opaque_busy_c6146", 32'(busy_at6146), 32'd0);

        // Clipping at (-10, 60)
        start_blit(8'hF6, 8'd60, 1'b0, 1'b0);
        wait_done("clip");
        chk("clip_writes",     32'(wr_cnt),     32'd344);
        chk("clip_first_addr", 32'(first_addr), 32'd5760);
        chk("clip_first_src",  32'(first_src),  32'd10);
        chk("clip_done_cycle", 32'(done_rel),   32'd6146);

        // Horizontal flip
        start_blit(8'd0, 8'd0, 1'b1, 1'b0);
        wait_done("flip");
        chk("flip_writes",  32'(wr_cnt),    32'd6144);
        chk("flip_src0",    32'(addr_of0),  32'd95);
        chk("flip_src95",   32'(addr_of95), 32'd0);

        // Transparency, then tint
        mode = 1;
        start_blit(8'd0, 8'd0, 1'b0, 1'b0);
        wait_done("transp");
        chk("transp_writes", 32'(wr_cnt),     32'd1);
        chk("transp_addr",   32'(first_addr), 32'd2249);
        chk("transp_data",   32'(first_data), 32'hFFDF);
        start_blit(8'd0, 8'd0, 1'b0, 1'b1);
        wait_done("tint");
        chk("tint_writes", 32'(wr_cnt),     32'd1);
        chk("tint_addr",   32'(first_addr), 32'd2249);
`ifdef BLIT_TINT_EN
        chk("tint_data",   32'(first_data), 32'hF800);
`else
        chk("tint_data",   32'(first_data), 32'hFFDF);
`endif

        // Second start at cycle 50 with a different offset is ignored
        mode = 0;
        start_blit(8'd0, 8'd0, 1'b0, 1'b0);
        repeat (49) @(negedge clk);
        start = 1'b1;
        pos_x = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("restart");
        chk("restart_done_cycle", 32'(done_rel), 32'd6146);
        chk("restart_done_count", 32'(done_cnt), 32'd1);
        chk("restart_writes",     32'(wr_cnt),   32'd6144);
        chk("restart_map_err",    32'(map_err),  32'd0);

        // Reset sampled in cycle 100 of a run, held two cycles
        start_blit(8'd0, 8'd0, 1'b0, 1'b0);
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy",        32'(busy),        32'd0);
        chk("midrst_fb_we",       32'(fb_we),       32'd0);
        chk("midrst_pixel_index", 32'(pixel_index), 32'd0);
        chk("midrst_fb_addr",     32'(fb_addr),     32'd0);
        chk("midrst_done",        32'(done),        32'd0);
        @(negedge clk);
        reset = 1'b0;
        clear_stats();
        repeat (100) @(negedge clk);
        chk("midrst_no_writes", 32'(wr_cnt), 32'd0);
        start_blit(8'd0, 8'd0, 1'b0, 1'b0);
        wait_done("after_rst");
        chk("after_rst_done_cycle", 32'(done_rel), 32'd6146);
        chk("after_rst_writes",     32'(wr_cnt),   32'd6144);
        chk("after_rst_map_err",    32'(map_err),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
